// File: rtl/pe_switch_pkg.sv
// Shared constants and config-field helpers for the elastic PE switch matrix.
package pe_switch_pkg;

  localparam logic MODE_BYPASS = 1'b0;
  localparam logic MODE_BUF    = 1'b1;

  // Each output owns a (SEL_W+1)-bit config slot: select field low, mode bit on top.
  function automatic int cfg_sel_lsb(input int o, input int sel_w);
    return o * (sel_w + 1);
  endfunction

  function automatic int cfg_mode_pos(input int o, input int sel_w);
    return o * (sel_w + 1) + sel_w;
  endfunction

endpackage

// File: rtl/pe_skid_fifo2.sv
// Two-entry elastic buffer used on a buffered switch output; data reads as zero when empty.
module pe_skid_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             UserCLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             acc,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [1:0]       count_q, count_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             do_push, do_pop;

  assign acc     = (count_q != 2'd2);
  assign valid   = (count_q != 2'd0);
  assign data    = valid ? mem_q[rd_q] : '0;
  assign do_push = push & acc;
  assign do_pop  = pop & valid;

  always_comb begin
    count_d  = count_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (flush) begin
      count_d = 2'd0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = ~wr_q;
      end
      if (do_pop) rd_d = ~rd_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      count_q <= 2'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Payload storage carries no reset; the empty-state mask on data hides stale entries.
  always_ff @(posedge UserCLK) begin
    mem_q[0] <= mem_d[0];
    mem_q[1] <= mem_d[1];
  end

endmodule

// File: rtl/pe_elastic_switch_matrix.sv
// Elastic N_IN x N_OUT PE switch: per-output source select, eager fork fan-out,
// and per-output choice of combinational bypass or 2-entry registered buffer.
module pe_elastic_switch_matrix
  import pe_switch_pkg::*;
#(
  parameter  int WIDTH        = 32,
  parameter  int N_IN         = 9,
  parameter  int N_OUT        = 4,
  localparam int SEL_W        = $clog2(N_IN + 1),
  localparam int NoConfigBits = N_OUT * (SEL_W + 1)
) (
  input  logic                    UserCLK,
  input  logic                    RST,
  input  logic [NoConfigBits-1:0] ConfigBits,
  input  logic                    cfg_flush,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  output logic [N_OUT*WIDTH-1:0]  out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready
);

  logic [N_OUT-1:0][SEL_W-1:0] sel;
  logic [N_OUT-1:0][WIDTH-1:0] src_d;
  logic [N_OUT-1:0][WIDTH-1:0] fifo_d;
  logic [N_OUT-1:0]            mode;
  logic [N_OUT-1:0]            src_v;
  logic [N_OUT-1:0]            src_fire;
  logic [N_OUT-1:0]            acc;
  logic [N_OUT-1:0]            push;
  logic [N_OUT-1:0]            done_q, done_d;
  logic [N_OUT-1:0]            fifo_acc;
  logic [N_OUT-1:0]            fifo_v;
  logic [N_IN-1:0]             any_sel;
  logic [N_IN-1:0]             all_ok;

  // Select codes >= N_IN match no source, so tied-off outputs see src_v=0 and join no fork.
  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      src_v[o] = 1'b0;
      src_d[o] = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (sel[o] == SEL_W'(i)) begin
          src_v[o] = in_valid[i];
          src_d[o] = in_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      acc[o]  = (mode[o] == MODE_BUF) ? fifo_acc[o] : out_ready[o];
      push[o] = src_v[o] & ~done_q[o] & acc[o] & ~cfg_flush;
    end
  end

  // A source is ready once every selecting output has either taken the token or can take it now.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      any_sel[i] = 1'b0;
      all_ok[i]  = 1'b1;
      for (int o = 0; o < N_OUT; o++) begin
        if (sel[o] == SEL_W'(i)) begin
          any_sel[i] = 1'b1;
          if (!(done_q[o] | acc[o])) all_ok[i] = 1'b0;
        end
      end
      in_ready[i] = any_sel[i] & all_ok[i] & ~cfg_flush;
    end
  end

  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      src_fire[o] = 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        if (sel[o] == SEL_W'(i)) src_fire[o] = in_valid[i] & in_ready[i];
      end
    end
  end

  always_comb begin
    done_d = done_q;
    for (int o = 0; o < N_OUT; o++) begin
      if (cfg_flush)     done_d[o] = 1'b0;
      else if (src_fire[o]) done_d[o] = 1'b0;
      else if (push[o])  done_d[o] = 1'b1;
    end
  end

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) done_q <= '0;
    else     done_q <= done_d;
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    assign sel[o]  = ConfigBits[cfg_sel_lsb(o, SEL_W) +: SEL_W];
    assign mode[o] = ConfigBits[cfg_mode_pos(o, SEL_W)];

    pe_skid_fifo2 #(
      .WIDTH(WIDTH)
    ) u_fifo (
      .UserCLK  (UserCLK),
      .RST      (RST),
      .flush    (cfg_flush),
      .push     (push[o] & (mode[o] == MODE_BUF)),
      .push_data(src_d[o]),
      .acc      (fifo_acc[o]),
      .pop      (out_ready[o] & fifo_v[o]),
      .valid    (fifo_v[o]),
      .data     (fifo_d[o])
    );

    assign out_valid[o] = ~cfg_flush &
                          ((mode[o] == MODE_BUF) ? fifo_v[o] : (src_v[o] & ~done_q[o]));
    assign out_data[o*WIDTH +: WIDTH] = (mode[o] == MODE_BUF) ? fifo_d[o] : src_d[o];
  end

endmodule

// File: doc/pe_elastic_switch_matrix.md
Name: pe_elastic_switch_matrix

Overview:
- Parametrised successor to the PE switch matrix: routes N_IN data sources to N_OUT sinks, each sink with its own configured source select.
- Adds valid/ready elastic handshaking, eager-fork fan-out (one source feeding several sinks) and a per-output mode: combinational bypass or a 2-entry registered buffer.
- Sits between PE neighbour ports and the ALU/register inputs inside a PE tile; configuration is static, taken from the tile config bits.

Parameters:
- WIDTH, 32, data width of every channel.
- N_IN, 9, number of source channels.
- N_OUT, 4, number of sink channels.
- SEL_W, $clog2(N_IN+1), select field width per output (derived; not overridden).
- NoConfigBits, N_OUT*(SEL_W+1), total config width.

Ports:
- UserCLK  input  1  fabric user clock; all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- ConfigBits  input  NoConfigBits  per output o, bits [o*(SEL_W+1) +: SEL_W] = sel[o], bit [o*(SEL_W+1)+SEL_W] = mode[o] (0 bypass, 1 buffered).
- cfg_flush  input  1  synchronous clear of buffers and fork state.
- in_data  input  N_IN*WIDTH  packed source data; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  N_IN  source valid.
- in_ready  output  N_IN  source ready.
- out_data  output  N_OUT*WIDTH  packed sink data.
- out_valid  output  N_OUT  sink valid.
- out_ready  input  N_OUT  sink ready.

Behaviour:
- Reset (async, RST=1): all buffers empty, all done[] bits 0. out_valid=0, out_data=0, in_ready=0 for unselected sources. Buffered outputs are empty, so their path is ready.
- Select: sel[o] < N_IN routes source sel[o]. sel[o] >= N_IN is a GND tie-off: out_valid[o]=0, out_data[o]=0, and the output never participates in any fork.
- Per-output accept, acc[o]:
  - Bypass: acc[o] = out_ready[o].
  - Buffered: acc[o] = buffer not full.
- Per-output push, push[o] = in_valid[sel[o]] & ~done[o] & acc[o].
- Fork rule: in_ready[i] = 1 iff at least one output selects i, and every selecting output has (done[o] | acc[o]). A source with no selecting output has in_ready=0; it stalls and data is never dropped.
- Source handshake fires when in_valid[i] & in_ready[i]. On fire, done[o] clears for every o selecting i. Otherwise done[o] is set when push[o] occurs. Each token is therefore delivered exactly once per selecting output.
- Bypass mode:
  - out_data[o] = in_data[sel[o]]; out_valid[o] = in_valid[sel[o]] & ~done[o].
  - Zero latency; a combinational ready path exists from out_ready to in_ready.
- Buffered mode:
  - 2-entry FIFO per output (registers + 1-bit rd/wr pointers + 2-bit count).
  - out_valid = count != 0; out_data = head entry.
  - Latency 1 cycle; full throughput of 1 token/cycle under continuous out_ready.
  - No combinational path from out_ready to in_ready.
  - Simultaneous push and pop at count=2 is not possible (acc=0 when full). At count=1, push and pop in the same cycle keeps count=1 and the data order is preserved.
- Pointers wrap modulo 2. count never exceeds 2, and never underflows because pop only occurs when out_valid.
- cfg_flush=1: next edge empties all FIFOs and clears all done[]. While cfg_flush=1, in_ready=0 and out_valid=0.
- Config change rule: ConfigBits may change only during cfg_flush=1 or in reset; behaviour on any other change is undefined.
- RST mid-transfer discards buffered tokens immediately.
- A held in_valid with stable in_data until fire is required of sources.

Decomposition:
- Package pe_switch_pkg holds:
  - the mode encoding constants MODE_BYPASS=0 and MODE_BUF=1;
  - a function that extracts sel/mode fields from ConfigBits.
- One sub-module, pe_skid_fifo2 (WIDTH param; push/acc/pop/valid/data, UserCLK, RST, flush), instantiated per output. It is bypassed by a generate mux when mode=0.

Test Plan:
- Reset/idle: RST pulse mid-run with out0 buffered holding 2 tokens -> out_valid=0 and out_data=0 immediately; after release, the first push appears on out_valid one cycle later.
- Bypass route: sel[0]=2, mode=0, in_valid[2]=1, in_data=0xDEADBEEF, out_ready[0]=1 -> same-cycle out_data[0]=0xDEADBEEF, out_valid[0]=1, in_ready[2]=1.
- Buffered backpressure: sel[1]=0, mode=1, stream 0x1,0x2,0x3 with out_ready[1]=0 -> in_ready[0] drops after 2 accepts. Then raise out_ready -> output order is 0x1,0x2,0x3 with no loss or duplication.
- Fork: out0 and out1 both sel=4 (bypass), out_ready[0]=1, out_ready[1]=0 for 3 cycles with token 0xA5 held:
  - cycle 1: out0 receives 0xA5 once; done[0]=1; in_ready[4]=0;
  - when out_ready[1] rises: out1 receives 0xA5 and in_ready[4]=1 that cycle;
  - next token 0x5A reaches both outputs.
- Tie-off and unselected: sel[3]=N_IN -> out_valid[3]=0 and out_data[3]=0 regardless of inputs. Source 8 selected by no output -> in_ready[8]=0.
- Flush: out2 buffered with 1 token, cfg_flush=1 for one cycle, then change sel[2] 1->3 -> old token never appears; the new source's token appears with 1-cycle latency.
